shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, datapath width in bits; only 8 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a shift operation; sampled only in IDLE.
REQ-005 Port: din  input  8  operand, captured on the edge that accepts start.
REQ-006 Port: amount  input  3  shift count N (0..7), captured with din.
REQ-007 Port: busy  output  1  high while an accepted operation is in progress, including the DONE cycle.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: dout  output  8  shift register contents; holds its value until the next accepted start.
REQ-010 Port: cout_last  output  1  bit shifted out by the most recent step.
REQ-011 Port: ovf  output  1  sticky OR of every bit shifted out during the current operation.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load dout<=din and cnt<=amount, clear cout_last and ovf, and go to SHIFT (N>0) or DONE (N=0).
REQ-014 Each SHIFT cycle SHALL perform one step:
- dout<={dout[6:0],fill}
- cout_last<=dout[7]
- ovf<=ovf|dout[7]
- cnt<=cnt-1
REQ-015 SHIFT SHALL go to DONE on the step where cnt==1, so exactly N steps are performed.
REQ-016 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-017 Timing: done SHALL be high in the cycle following the Nth edge after the accepting edge; for N=0, in the cycle immediately after the accepting edge.
REQ-018 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; din and amount changes while busy SHALL NOT affect the result.
REQ-020 start held high continuously SHALL be accepted again on the first IDLE cycle after DONE.
REQ-021 Shift-out bits are not widened; bits beyond position 7 are visible only via cout_last and ovf.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE and cnt=0, and dout, cout_last, ovf, busy and done to 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard that operation; no done pulse is produced for it.
REQ-025 After rst deasserts, the first start sampled in IDLE SHALL be accepted normally.

Configuration
REQ-026 Macro SHIFT_ROTATE_EN SHALL select the fill bit:
- defined: fill=dout[7] (rotate left).
- undefined: fill=0 (logical shift left).
REQ-027 ovf, cout_last, timing and handshake SHALL be identical with and without SHIFT_ROTATE_EN.

Verification
REQ-028 din=0x01, N=3, start pulse -> done high after 3rd edge following acceptance; dout=0x08, cout_last=0, ovf=0, busy high 4 cycles.
REQ-029 din=0x81, N=1 -> dout=0x02 (0x03 with SHIFT_ROTATE_EN), cout_last=1, ovf=1.
REQ-030 din=0xA5, N=0 -> done in cycle right after acceptance; dout=0xA5, cout_last=0, ovf=0.
REQ-031 din=0xF0, N=7 -> dout=0x00 (0x78 with SHIFT_ROTATE_EN), cout_last=0, ovf=1.
REQ-032 start=1 with din=0xFF, N=7 while busy on a din=0x01, N=3 job -> ignored; result 0x08 with a single done pulse.
REQ-033 rst pulsed during SHIFT of din=0x01, N=5 -> all outputs 0 at once, no done; next start din=0x02, N=1 -> dout=0x04.

Source files
------------

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle left shifter: one bit per clock, with carry-out and sticky overflow
// Optional feature macro: SHIFT_ROTATE_EN (defined: rotate left, fill=dout[7]; undefined: logical shift, fill=0)
module shift_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout_last,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic       fill;

`ifdef SHIFT_ROTATE_EN
  assign fill = dout[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, count down steps in SHIFT, single-cycle DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (amount == 3'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'd1) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status: load on accept, one shift step per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      dout      <= '0;
      cout_last <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dout      <= din;
            cnt       <= amount;
            cout_last <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        SHIFT: begin
          dout      <= {dout[WIDTH-2:0], fill};
          cout_last <= dout[WIDTH-1];
          ovf       <= ovf | dout[WIDTH-1];
          cnt       <= cnt - 3'd1;
        end
        default: ;
      endcase
      // busy/done are registered copies of the state being entered, so they
      // line up exactly with SHIFT/DONE without any input-to-output path.
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer against an arithmetic reference model
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       cout_last;
  logic       ovf;

  int checks;
  int errors;

  shift_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .amount    (amount),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .cout_last (cout_last),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shifting left by n is multiplication by 2**n into a
  // 16-bit word; the upper byte holds everything shifted out.
  function automatic logic [7:0] ref_dout(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] w;
    w = {8'h00, d} << n;
`ifdef SHIFT_ROTATE_EN
    return w[7:0] | w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  function automatic logic ref_ovf(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] w;
    w = {8'h00, d} << n;
    return (w[15:8] != 8'h00);
  endfunction

  function automatic logic ref_cl(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] w;
    w = {8'h00, d} << n;
    return (n == 3'd0) ? 1'b0 : w[8];
  endfunction

  // Drives one operation (start at the next edge) and observes it until IDLE.
  // mode 0: quiet while busy; 1: random start/din/amount while busy;
  // mode 2: start=1, din=FF, amount=7 while busy.
  task automatic do_op(input logic [7:0] d, input logic [2:0] n, input int mode,
                       output logic [7:0] o_dout, output logic o_cl, output logic o_ovf,
                       output int lat, output int bc, output int dp, output bit timeout);
    start = 1'b1; din = d; amount = n;
    lat = -1; bc = 0; dp = 0; timeout = 1'b1;
    o_dout = 8'h00; o_cl = 1'b0; o_ovf = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      if (done) begin
        dp++; lat = i; o_dout = dout; o_cl = cout_last; o_ovf = ovf;
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      case (mode)
        1: begin start = 1'($urandom); din = 8'($urandom); amount = 3'($urandom); end
        2: begin start = 1'b1; din = 8'hFF; amount = 3'd7; end
        default: start = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = 8'h00; amount = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dout, cout_last, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dout=%h cl=%b ovf=%b, want all 0",
               busy, done, dout, cout_last, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] td [4] = '{8'h01, 8'h81, 8'hA5, 8'hF0};
    logic [2:0] tn [4] = '{3'd3, 3'd1, 3'd0, 3'd7};
    logic [7:0] o_d; logic o_c, o_o; int lat, bc, dp; bit to;
    for (int k = 0; k < 4; k++) begin
      do_op(td[k], tn[k], 0, o_d, o_c, o_o, lat, bc, dp, to);
      checks++;
      if (to !== 1'b0 || lat !== int'(tn[k]) || bc !== int'(tn[k]) + 1 || dp !== 1) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d done_pulses=%0d timeout=%b, want %0d %0d 1 0",
                 k, lat, bc, dp, to, tn[k], tn[k] + 1);
      end
      checks++;
      if (o_d !== ref_dout(td[k], tn[k]) || o_c !== ref_cl(td[k], tn[k]) || o_o !== ref_ovf(td[k], tn[k])) begin
        errors++;
        $display("FAIL directed_result[%0d]: got dout=%h cl=%b ovf=%b, want %h %b %b",
                 k, o_d, o_c, o_o, ref_dout(td[k], tn[k]), ref_cl(td[k], tn[k]), ref_ovf(td[k], tn[k]));
      end
      checks++;
      if (dout !== ref_dout(td[k], tn[k])) begin
        errors++;
        $display("FAIL directed_hold[%0d]: got dout=%h in IDLE, want %h", k, dout, ref_dout(td[k], tn[k]));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, o_d; logic [2:0] n; logic o_c, o_o; int lat, bc, dp; bit to;
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom); n = 3'($urandom);
      do_op(d, n, 1, o_d, o_c, o_o, lat, bc, dp, to);
      checks++;
      if (to !== 1'b0 || lat !== int'(n) || bc !== int'(n) + 1 || dp !== 1 ||
          o_d !== ref_dout(d, n) || o_c !== ref_cl(d, n) || o_o !== ref_ovf(d, n)) begin
        errors++;
        $display("FAIL random[%0d] din=%h n=%0d: got dout=%h cl=%b ovf=%b lat=%0d bc=%0d dp=%0d to=%b, want %h %b %b %0d %0d 1 0",
                 k, d, n, o_d, o_c, o_o, lat, bc, dp, to,
                 ref_dout(d, n), ref_cl(d, n), ref_ovf(d, n), n, n + 1);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] o_d; logic o_c, o_o; int lat, bc, dp; bit to;
    do_op(8'h01, 3'd3, 2, o_d, o_c, o_o, lat, bc, dp, to);
    checks++;
    if (to !== 1'b0 || dp !== 1 || bc !== 4 || o_d !== 8'h08 || o_c !== 1'b0 || o_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: got dout=%h cl=%b ovf=%b bc=%0d dp=%0d to=%b, want 08 0 0 4 1 0",
               o_d, o_c, o_o, bc, dp, to);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || dout !== 8'h08) begin
      errors++;
      $display("FAIL ignore_busy_idle: got busy=%b dout=%h, want 0 08", busy, dout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int phase;
    n = int'($urandom_range(0, 4));
    start = 1'b1; din = 8'h01; amount = 3'(n);
    for (int k = 1; k <= 3 * (n + 2); k++) begin
      @(posedge clk); #1;
      phase = (k - 1) % (n + 2);
      checks++;
      if (busy !== (phase <= n) || done !== (phase == n)) begin
        errors++;
        $display("FAIL back_to_back n=%0d cycle %0d: got busy=%b done=%b, want %b %b",
                 n, k, busy, done, phase <= n, phase == n);
      end
    end
    start = 1'b0;
    repeat (n + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] o_d; logic o_c, o_o; int lat, bc, dp; bit to;
    int done_seen;
    start = 1'b1; din = 8'h01; amount = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dout, cout_last, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b dout=%h cl=%b ovf=%b, want all 0",
               busy, done, dout, cout_last, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d busy/done cycles after reset, want 0", done_seen);
    end
    do_op(8'h02, 3'd1, 0, o_d, o_c, o_o, lat, bc, dp, to);
    checks++;
    if (to !== 1'b0 || dp !== 1 || lat !== 1 || o_d !== 8'h04 || o_c !== 1'b0 || o_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: got dout=%h cl=%b ovf=%b lat=%0d dp=%0d to=%b, want 04 0 0 1 1 0",
               o_d, o_c, o_o, lat, dp, to);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
